hazard_control_unit: RTL

Parametrised pipeline hazard and interrupt controller for the pipelined CPU, and the successor of the fixed five-stage hazard logic. It detects load-use and branch data hazards against a configurable number of in-flight destination stages, and arbitrates user pause, PC-overflow UART reload and up to `WAIT_CNT` prioritised blocking I/O waits. It drives a per-stage `HOLD`/`NO_OP`/`NORMAL` control vector, the UART enable and the VGA status outputs. It adds a drain phase before UART hand-off and a stall-cycle counter.

---
 rtl/hazard_control_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard, pause/UART drain and blocking-wait controller
// All state advances on the falling clock edge; every output is a registered flop.
module hazard_control_unit #(
  parameter int                    STAGE_CNT  = 5,
  parameter int                    FWD_DEPTH  = 2,
  parameter int                    REG_ADDR_W = 5,
  parameter int                    ISA_W      = 32,
  parameter logic [ISA_W-1:0]      PC_MAX     = 32'h0000_3FFC,
  parameter int                    WAIT_CNT   = 2,
  localparam int                   WID_W      = (WAIT_CNT > 1) ? $clog2(WAIT_CNT) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            uart_complete,
  input  logic                            reg_1_valid,
  input  logic                            reg_2_valid,
  input  logic                            branch_instruction,
  input  logic [REG_ADDR_W-1:0]           id_reg_1_idx,
  input  logic [REG_ADDR_W-1:0]           id_reg_2_idx,
  input  logic [FWD_DEPTH-1:0]            fwd_write_enable,
  input  logic [FWD_DEPTH-1:0]            fwd_no_op,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] fwd_reg_dest_idx,
  input  logic                            ex_mem_read_enable,
  input  logic [ISA_W-1:0]                pc_next,
  input  logic                            cpu_pause,
  input  logic                            cpu_resume,
  input  logic [WAIT_CNT-1:0]             wait_req,
  input  logic [WAIT_CNT-1:0]             wait_done,
  output logic                            uart_disable,
  output logic                            pc_reset,
  output logic [2*STAGE_CNT-1:0]          hazard_control,
  output logic [1:0]                      cpu_state,
  output logic [2:0]                      issue_type,
  output logic [WID_W-1:0]                wait_id,
  output logic [31:0]                     stall_cycles
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_EXECUTE   = 2'd1;
  localparam logic [1:0] ST_HAZARD    = 2'd2;
  localparam logic [1:0] ST_INTERRUPT = 2'd3;

  localparam logic [2:0] ISS_NONE  = 3'd0;
  localparam logic [2:0] ISS_DATA  = 3'd1;
  localparam logic [2:0] ISS_UART  = 3'd2;
  localparam logic [2:0] ISS_PAUSE = 3'd3;
  localparam logic [2:0] ISS_WAIT  = 3'd4;

  localparam logic [1:0] CTL_HOLD  = 2'b01;
  localparam logic [1:0] CTL_NO_OP = 2'b10;

  localparam int                     DRN_W      = (STAGE_CNT > 1) ? $clog2(STAGE_CNT) : 1;
  localparam logic [DRN_W-1:0]       DRAIN_INIT = DRN_W'(STAGE_CNT - 1);
  localparam logic [2*STAGE_CNT-1:0] HC_ALL_NOP = {STAGE_CNT{CTL_NO_OP}};

  logic [1:0]             state_q, state_d;
  logic [2:0]             issue_q, issue_d;
  logic [2*STAGE_CNT-1:0] hc_q, hc_d;
  logic                   uart_disable_q, uart_disable_d;
  logic                   pc_reset_q, pc_reset_d;
  logic [WID_W-1:0]       wait_id_q, wait_id_d;
  logic [31:0]            stall_q, stall_d;
  logic [DRN_W-1:0]       drain_q, drain_d;

  logic [FWD_DEPTH-1:0]   conflict;
  logic [WAIT_CNT-1:0]    wait_pend;
  logic [WID_W-1:0]       wait_sel;
  logic                   data_hazard, uart_hazard, wait_hit;
  logic                   drained, drain_exit, wait_exit;
  logic [2*STAGE_CNT-1:0] hc_data, hc_drain;

  always_comb begin
    conflict = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      conflict[k] = fwd_write_enable[k] & ~fwd_no_op[k] &
        ((reg_1_valid & (id_reg_1_idx == fwd_reg_dest_idx[k*REG_ADDR_W +: REG_ADDR_W])) |
         (reg_2_valid & (id_reg_2_idx == fwd_reg_dest_idx[k*REG_ADDR_W +: REG_ADDR_W])));
    end
  end

  assign data_hazard = (branch_instruction & (|conflict)) | (ex_mem_read_enable & conflict[0]);
  assign uart_hazard = pc_next > PC_MAX;
  assign wait_pend   = wait_req & ~wait_done;
  assign wait_hit    = |wait_pend;

  // Scan downward so the lowest pending index wins.
  always_comb begin
    wait_sel = '0;
    for (int i = WAIT_CNT - 1; i >= 0; i--) begin
      if (wait_pend[i]) wait_sel = WID_W'(i);
    end
  end

  assign drained    = (drain_q == '0);
  assign drain_exit = drained & uart_complete & ((issue_q == ISS_UART) | cpu_resume);
  assign wait_exit  = wait_done[wait_id_q] | ~wait_req[wait_id_q];

  always_comb begin
    hc_data        = '0;
    hc_data[1:0]   = CTL_HOLD;
    hc_data[3:2]   = CTL_HOLD;
    hc_data[5:4]   = CTL_NO_OP;
    hc_drain       = '0;
    hc_drain[1:0]  = CTL_NO_OP;
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      issue_q        <= ISS_NONE;
      hc_q           <= '0;
      uart_disable_q <= 1'b1;
      pc_reset_q     <= 1'b0;
      wait_id_q      <= '0;
      stall_q        <= '0;
      drain_q        <= '0;
    end else begin
      state_q        <= state_d;
      issue_q        <= issue_d;
      hc_q           <= hc_d;
      uart_disable_q <= uart_disable_d;
      pc_reset_q     <= pc_reset_d;
      wait_id_q      <= wait_id_d;
      stall_q        <= stall_d;
      drain_q        <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (data_hazard | cpu_pause | uart_hazard) state_d = ST_HAZARD;
        else if (wait_hit)                         state_d = ST_INTERRUPT;
      end
      ST_HAZARD: begin
        if ((issue_q == ISS_DATA) ? ~data_hazard : drain_exit) state_d = ST_EXECUTE;
      end
      ST_INTERRUPT: if (wait_exit) state_d = ST_EXECUTE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_d        = issue_q;
    hc_d           = hc_q;
    uart_disable_d = uart_disable_q;
    pc_reset_d     = 1'b0;
    wait_id_d      = wait_id_q;
    drain_d        = drain_q;
    stall_d        = ((state_q != ST_EXECUTE) && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;
    case (state_q)
      ST_EXECUTE: begin
        if (data_hazard) begin
          issue_d = ISS_DATA;
          hc_d    = hc_data;
        end else if (cpu_pause | uart_hazard) begin
          issue_d = cpu_pause ? ISS_PAUSE : ISS_UART;
          hc_d    = hc_drain;
          drain_d = DRAIN_INIT;
        end else if (wait_hit) begin
          issue_d   = ISS_WAIT;
          hc_d      = HC_ALL_NOP;
          wait_id_d = wait_sel;
        end
      end
      ST_HAZARD: begin
        if (issue_q == ISS_DATA) begin
          if (!data_hazard) begin
            issue_d = ISS_NONE;
            hc_d    = '0;
          end
        end else if (drain_exit) begin
          issue_d        = ISS_NONE;
          hc_d           = '0;
          uart_disable_d = 1'b1;
          pc_reset_d     = (issue_q == ISS_UART);
        end else if (!drained) begin
          // UART is released on the same edge the counter lands on zero.
          drain_d        = drain_q - DRN_W'(1);
          uart_disable_d = (drain_q != DRN_W'(1));
        end else begin
          uart_disable_d = 1'b0;
        end
      end
      ST_INTERRUPT: begin
        if (wait_exit) begin
          issue_d   = ISS_NONE;
          hc_d      = '0;
          wait_id_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign uart_disable   = uart_disable_q;
  assign pc_reset       = pc_reset_q;
  assign hazard_control = hc_q;
  assign cpu_state      = state_q;
  assign issue_type     = issue_q;
  assign wait_id        = wait_id_q;
  assign stall_cycles   = stall_q;

endmodule
